// File: rtl/hilo_div_pkg.sv
// Shared definitions for the HI/LO divider: state encodings,
// iteration count and the DIV/DIVU funct codes used by execute.
package hilo_div_pkg;

  localparam int DIV_DATA_WIDTH = 32;
  localparam int DIV_CYCLES     = DIV_DATA_WIDTH;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_RUN  = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

endpackage

// File: rtl/hilo_div_unit_div_step.sv
// One restoring-division iteration (combinational).
// Ports: rem/quo/divisor in; rem_nxt/quo_nxt out.
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] rem,
  input  logic [W-1:0] quo,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] rem_nxt,
  output logic [W-1:0] quo_nxt
);

  logic [W:0] shifted;
  logic [W:0] trial;
  logic       borrow;

  // rem < divisor holds between steps, so the top bit of
  // the W+1 bit difference is exactly the borrow.
  always_comb begin
    shifted = {rem, quo[W-1]};
    trial   = shifted - {1'b0, divisor};
    borrow  = trial[W];
    rem_nxt = borrow ? shifted[W-1:0] : trial[W-1:0];
    quo_nxt = {quo[W-2:0], ~borrow};
  end

endmodule

// File: rtl/hilo_div_unit.sv
// Multi-cycle radix-2 DIV/DIVU unit returning {rem, quo} as HI/LO.
// Ports: clk, rst (async low), start, signed_div, dividend, divisor,
// cancel -> busy, done, hi_out (rem), lo_out (quo).
// Option: HILO_DIV_ZERO_FAST_EN finishes divide-by-zero in 1 cycle.
module hilo_div_unit
  import hilo_div_pkg::*;
#(
  parameter int DATA_WIDTH = DIV_DATA_WIDTH,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_div,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  input  logic                  cancel,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out
);

  localparam int MSB = DATA_WIDTH - 1;

  typedef logic [DATA_WIDTH-1:0] word_t;

  div_state_e           state;
  div_state_e           state_nxt;
  word_t                rem_q;
  word_t                quo_q;
  word_t                dvs_q;
  word_t                rem_nxt;
  word_t                quo_nxt;
  word_t                dvd_abs;
  word_t                dvs_abs;
  word_t                rem_fix;
  word_t                quo_fix;
  logic                 q_neg;
  logic                 r_neg;
  logic                 q_neg_in;
  logic                 r_neg_in;
  logic                 accept;
  logic                 last;
  logic                 zero_fast;
  logic [CNT_WIDTH-1:0] cnt;

  function automatic word_t neg(word_t x);
    return ~x + DATA_WIDTH'(1);
  endfunction

  assign r_neg_in = signed_div & dividend[MSB];
  assign q_neg_in = signed_div & (dividend[MSB] ^ divisor[MSB]);
  assign dvd_abs  = r_neg_in ? neg(dividend) : dividend;
  assign dvs_abs  = (signed_div & divisor[MSB]) ? neg(divisor)
                                                : divisor;
  assign accept   = start & ~cancel & (state != DIV_RUN);
  assign last     = (cnt == CNT_WIDTH'(DATA_WIDTH - 1));
  assign rem_fix  = r_neg ? neg(rem_nxt) : rem_nxt;
  assign quo_fix  = q_neg ? neg(quo_nxt) : quo_nxt;

`ifdef HILO_DIV_ZERO_FAST_EN
  assign zero_fast = (divisor == '0);
`else
  assign zero_fast = 1'b0;
`endif

  div_step #(
    .W(DATA_WIDTH)
  ) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (cancel) begin
      state_nxt = DIV_IDLE;
    end else begin
      unique case (state)
        DIV_IDLE,
        DIV_DONE: begin
          if (start) begin
            state_nxt = zero_fast ? DIV_DONE : DIV_RUN;
          end else begin
            state_nxt = DIV_IDLE;
          end
        end
        DIV_RUN: begin
          if (last) begin
            state_nxt = DIV_DONE;
          end
        end
        default: state_nxt = DIV_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == DIV_RUN);
    done = (state == DIV_DONE);
  end

  // Results are written on the edge that enters DONE so they are
  // already valid while done is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      cnt    <= '0;
      hi_out <= '0;
      lo_out <= '0;
    end else if (accept) begin
      rem_q <= '0;
      quo_q <= dvd_abs;
      dvs_q <= dvs_abs;
      q_neg <= q_neg_in;
      r_neg <= r_neg_in;
      cnt   <= '0;
      if (zero_fast) begin
        hi_out <= dividend;
        lo_out <= q_neg_in ? DATA_WIDTH'(1) : '1;
      end
    end else if (state == DIV_RUN && !cancel) begin
      rem_q <= rem_nxt;
      quo_q <= quo_nxt;
      cnt   <= cnt + CNT_WIDTH'(1);
      if (last) begin
        hi_out <= rem_fix;
        lo_out <= quo_fix;
      end
    end
  end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Self-checking bench for hilo_div_unit: scoreboard of expected
// HI/LO values and done cycle, popped when done pulses.
module tb_hilo_div_unit;

`ifdef HILO_DIV_ZERO_FAST_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic        cancel;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_run  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  hilo_div_unit dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .dividend   (dividend),
    .divisor    (divisor),
    .cancel     (cancel),
    .busy       (busy),
    .done       (done),
    .hi_out     (hi_out),
    .lo_out     (lo_out)
  );

  task automatic check(string tag, logic [63:0] got,
                       logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(logic s, logic [31:0] a,
                                        logic [31:0] b);
    logic [31:0] aa, bb, q, r;
    aa = (s && a[31]) ? -a : a;
    bb = (s && b[31]) ? -b : b;
    if (bb == 0) begin
      q = '1;
      r = aa;
    end else begin
      q = aa / bb;
      r = aa % bb;
    end
    if (s && (a[31] ^ b[31])) q = -q;
    if (s && a[31]) r = -r;
    return {r, q};
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (rst && done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("hi", hi_out, e.hi);
        check("lo", lo_out, e.lo);
        check("done_cycle", cyc, e.due);
      end
    end
  end

  // Called at a negedge; returns one negedge later.
  task automatic issue(logic s, logic [31:0] a, logic [31:0] b,
                       bit push, logic [31:0] ehi,
                       logic [31:0] elo, int lat);
    exp_t e;
    start      = 1'b1;
    signed_div = s;
    dividend   = a;
    divisor    = b;
    if (push) begin
      e.hi  = ehi;
      e.lo  = elo;
      e.due = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic        s;
    logic [31:0] a, b;
    logic [63:0] m;

    rst        = 1'b0;
    start      = 1'b0;
    signed_div = 1'b0;
    cancel     = 1'b0;
    dividend   = '0;
    divisor    = '0;

    @(negedge clk);
    check("rst_flags", {busy, done}, 0);
    check("rst_hi", hi_out, 0);
    check("rst_lo", lo_out, 0);
    rst = 1'b1;
    @(negedge clk);

    issue(0, 100, 7, 1, 2, 14, 33);
    check("busy_c1", busy, 1);
    repeat (31) @(negedge clk);
    check("busy_c32", busy, 1);
    @(negedge clk);
    check("busy_c33", busy, 0);
    check("done_c33", done, 1);
    drain();

    issue(1, 32'hFFFF_FFF9, 2, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
    drain();
    issue(1, 7, 32'hFFFF_FFFE, 1, 1, 32'hFFFF_FFFD, 33);
    drain();
    issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0, 32'h8000_0000, 33);
    drain();
    issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 0, 33);
    drain();

    issue(0, 100, 7, 0, 0, 0, 33);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    check("cancel_busy", busy, 0);
    check("cancel_done", done, 0);
    check("cancel_hi", hi_out, 32'h8000_0000);
    check("cancel_lo", lo_out, 0);
    repeat (40) @(negedge clk);
    issue(0, 100, 7, 1, 2, 14, 33);
    drain();

    issue(0, 1000, 3, 1, 1, 333, 33);
    for (int i = 0; i < 40 && !done; i++) @(negedge clk);
    check("b2b_first_done", done, 1);
    issue(1, 32'hFFFF_FC18, 7, 1, 32'hFFFF_FFFA, 32'hFFFF_FF72, 33);
    drain();

    issue(0, 1000, 3, 1, 1, 333, 33);
    repeat (5) @(negedge clk);
    start      = 1'b1;
    signed_div = 1'b1;
    dividend   = 55;
    divisor    = 5;
    @(negedge clk);
    start = 1'b0;
    drain();

    issue(0, 5, 0, 1, 5, 32'hFFFF_FFFF, ZLAT);
    drain();
    issue(1, 32'hFFFF_FFFB, 0, 1, 32'hFFFF_FFFB, 1, ZLAT);
    drain();

    for (int i = 0; i < 16; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = (i % 4 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      if (b == 0) b = 1;
      m = model(s, a, b);
      issue(s, a, b, 1, m[63:32], m[31:0], 33);
      drain();
    end

    issue(0, 100, 7, 0, 0, 0, 33);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rstrun_flags", {busy, done}, 0);
    check("rstrun_hi", hi_out, 0);
    check("rstrun_lo", lo_out, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    issue(1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1, 32'hFFFF_FFFE, 14, 33);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
Multi-cycle radix-2 restoring divider that services DIV/DIVU issued by the execute stage. It is the responder side of the execute-stage mult/div request path.
- Execute raises a start pulse with the operands.
- This block holds the stall condition while it iterates.
- It returns {remainder, quotient} in the same HI/LO form the execute stage writes to HILO.
- Sits beside the execute stage; its outputs feed the execute stage's hilo write mux and stall_request.

Parameters:
- DATA_WIDTH, 32, operand width in bits; result is 2*DATA_WIDTH.
- CNT_WIDTH, 6, iteration counter width; must hold DATA_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- start  in  1  request pulse from execute; sampled in IDLE or DONE only.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled with start.
- dividend  in  DATA_WIDTH  operand_1; sampled with start.
- divisor  in  DATA_WIDTH  operand_2; sampled with start.
- cancel  in  1  flush from pipeline (exception/branch kill); aborts any operation.
- busy  out  1  high while iterating; execute ORs this into stall_request.
- done  out  1  one-cycle pulse, result valid.
- hi_out  out  DATA_WIDTH  remainder.
- lo_out  out  DATA_WIDTH  quotient.

Behaviour:
- Reset (rst=0, async): state=IDLE, busy=0, done=0, hi_out=0, lo_out=0, counter=0, internal regs=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and cancel=0: latch |dividend| and |divisor| (absolute value only if signed_div, else raw).
  - Also latch q_neg = signed_div & (dividend[MSB]^divisor[MSB]) and r_neg = signed_div & dividend[MSB].
  - Clear partial remainder, counter=0, go to RUN.
- RUN, each cycle:
  - Shift {rem, quo} left 1.
  - trial = rem_shifted - divisor_abs, computed at DATA_WIDTH+1 bits.
  - If no borrow: rem = trial and quotient LSB = 1; else quotient LSB = 0.
  - counter++.
  - After DATA_WIDTH iterations, go to DONE.
- DONE (one cycle):
  - done=1; hi_out/lo_out load sign-corrected results: quotient negated if q_neg, remainder negated if r_neg.
  - Next state is IDLE, or RUN if start=1 that cycle (back-to-back accepted).
- Latency: start high in cycle 0; busy=1 in cycles 1..32; done=1 in cycle 33 (DATA_WIDTH=32).
- busy is 0 in IDLE and DONE.
- hi_out/lo_out hold their last value until the next DONE; they are not cleared by IDLE or cancel.
- start during RUN: ignored.
- cancel, any state: next edge goes to IDLE, done stays 0, outputs unchanged; cancel wins over a simultaneous start.
- Divide by zero:
  - Runs the full iterations; every trial succeeds, so the raw quotient is all ones and the raw remainder is |dividend|.
  - Sign correction then applies. The result is deterministic but architecturally UNPREDICTABLE.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed): lo_out=0x80000000, hi_out=0. Modular arithmetic produces this naturally; no special-casing.
- Arithmetic is modular in DATA_WIDTH bits; negation is two's complement (~x+1).

Optional Feature:
- Macro: HILO_DIV_ZERO_FAST_EN.
- Defined:
  - divisor==0 at start goes IDLE to DONE directly; busy stays 0 and done pulses in cycle 1.
  - Outputs match the non-fast values: lo_out = q_neg ? 1 : 0xFFFFFFFF; hi_out = dividend.
- Undefined: divide-by-zero takes the full 33-cycle path.

Decomposition:
- Shared define file:
  - State encodings DIV_IDLE/DIV_RUN/DIV_DONE.
  - DIV_CYCLES constant (=DATA_WIDTH).
  - The DIV/DIVU funct codes the execute stage uses to generate start/signed_div.
- One natural sub-module: div_step, combinational single-iteration restoring step.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem and next quo.
  - Instantiated once; the FSM and sign handling stay in hilo_div_unit.

Test Plan:
- Unsigned: start, DIVU, 100/7 -> busy cycles 1..32, done in cycle 33, lo_out=14, hi_out=2.
- Signed: DIV -7/2 -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1). DIV 7/-2 -> lo_out=-3, hi_out=1.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> lo_out=0x80000000, hi_out=0. DIVU same operands -> lo_out=0, hi_out=0x80000000.
- Cancel: start 100/7, assert cancel in cycle 10 -> IDLE next edge, busy=0, no done, hi/lo keep previous values. A new start then completes normally at +33.
- Back-to-back and mid-run: start asserted again in the DONE cycle -> second result's done 33 cycles later. A start pulse during RUN is ignored, with no effect on the first result.
- Reset and divide-by-zero:
  - rst low mid-RUN -> immediate IDLE, all outputs 0.
  - DIVU 5/0 -> lo_out=0xFFFFFFFF, hi_out=5; done at cycle 33, or cycle 1 with HILO_DIV_ZERO_FAST_EN.
